// File: rtl/game_pkg.sv
// Shared game-control types and widths, used by the lives logic and the HUD.
package game_pkg;

  localparam int unsigned LIVES_W      = 3;
  localparam int unsigned MAX_LIVES_HW = 5;
  localparam int unsigned SCORE_W      = 16;
  localparam int unsigned FRAME_CNT_W  = 7;

  typedef enum logic [1:0] {
    StGameOver,
    StPlay,
    StDying,
    StRespawn
  } lives_state_t;

endpackage

// File: rtl/lives_manager_if.sv
// Signal bundle between game control and the lives manager.
// master = game control / HUD side, slave = lives_manager.
interface lives_manager_if;

  logic                              frame_tick;
  logic                              new_game;
  logic                              pacman_hit;
  logic [game_pkg::SCORE_W-1:0]      score;
  logic [game_pkg::LIVES_W-1:0]      lives;
  logic                              dying;
  logic [game_pkg::FRAME_CNT_W-1:0]  death_frame;
  logic                              freeze;
  logic                              respawn;
  logic                              game_over;

  modport master (
    output frame_tick, new_game, pacman_hit, score,
    input  lives, dying, death_frame, freeze, respawn, game_over
  );

  modport slave (
    input  frame_tick, new_game, pacman_hit, score,
    output lives, dying, death_frame, freeze, respawn, game_over
  );

endinterface

// File: rtl/lives_manager_frame_timer.sv
// Frame-tick counter with synchronous clear/enable. done flags the tick on which
// the count equals the runtime last index, so the caller can act on that edge.
module frame_timer
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [FRAME_CNT_W-1:0] last,
  output logic [FRAME_CNT_W-1:0] count,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] count_q;

  // Count enabled ticks; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign done  = enable && (count_q == last);

endmodule

// File: rtl/lives_manager.sv
// Life count and death/respawn sequencing. All outputs are registered and change
// on the clock edge after the causing input.
module lives_manager
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned MAX_LIVES      = MAX_LIVES_HW,
  parameter int unsigned BONUS_SCORE    = 10000,
  parameter int unsigned DEATH_FRAMES   = 90,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic           clk,
  input  logic           rst,
  lives_manager_if.slave bus
);

  lives_state_t           state_q;
  logic [LIVES_W-1:0]     lives_q;
  logic                   bonus_given_q;
  logic                   game_over_q;
  logic                   freeze_q;
  logic                   dying_q;
  logic [FRAME_CNT_W-1:0] death_frame_q;
  logic                   respawn_q;

  logic                   timed_state;
  logic                   timer_clear;
  logic                   timer_en;
  logic [FRAME_CNT_W-1:0] timer_last;
  logic [FRAME_CNT_W-1:0] timer_count;
  logic                   timer_done;
  logic                   bonus_fire;
  logic [LIVES_W-1:0]     lives_inc;

  // Timer steering: ticks only count while dying or in the READY pause.
  always_comb begin
    timed_state = (state_q == StDying) || (state_q == StRespawn);
    timer_en    = timed_state && bus.frame_tick;
    timer_clear = !timed_state || timer_done;
    timer_last  = (state_q == StDying) ? FRAME_CNT_W'(DEATH_FRAMES - 1)
                                       : FRAME_CNT_W'(RESPAWN_FRAMES - 1);
  end

  // One-shot bonus life, saturating at MAX_LIVES; never while no game runs.
  always_comb begin
    bonus_fire = (state_q != StGameOver) && !bonus_given_q &&
                 (32'(bus.score) >= BONUS_SCORE);
    lives_inc  = (lives_q >= LIVES_W'(MAX_LIVES)) ? lives_q : lives_q + 1'b1;
  end

  frame_timer u_frame_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .last   (timer_last),
    .count  (timer_count),
    .done   (timer_done)
  );

  // Game sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StGameOver;
      lives_q       <= '0;
      bonus_given_q <= 1'b0;
      game_over_q   <= 1'b1;
      freeze_q      <= 1'b1;
      dying_q       <= 1'b0;
      death_frame_q <= '0;
      respawn_q     <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      if (bonus_fire) begin
        bonus_given_q <= 1'b1;
        lives_q       <= lives_inc;
      end
      unique case (state_q)
        StGameOver: begin
          if (bus.new_game) begin
            lives_q       <= LIVES_W'(START_LIVES);
            bonus_given_q <= 1'b0;
            respawn_q     <= 1'b1;
            freeze_q      <= 1'b0;
            game_over_q   <= 1'b0;
            state_q       <= StPlay;
          end
        end
        StPlay: begin
          if (bus.pacman_hit) begin
            freeze_q      <= 1'b1;
            dying_q       <= 1'b1;
            death_frame_q <= '0;
            state_q       <= StDying;
          end
        end
        StDying: begin
          if (timer_done) begin
            dying_q       <= 1'b0;
            death_frame_q <= '0;
            if (bonus_fire) begin
              // Bonus and death on the same edge cancel out.
              lives_q <= lives_q;
              state_q <= StRespawn;
            end else if (lives_q == LIVES_W'(1)) begin
              lives_q     <= '0;
              game_over_q <= 1'b1;
              state_q     <= StGameOver;
            end else begin
              lives_q <= lives_q - 1'b1;
              state_q <= StRespawn;
            end
          end else if (bus.frame_tick) begin
            death_frame_q <= timer_count + 1'b1;
          end
        end
        StRespawn: begin
          if (timer_done) begin
            respawn_q <= 1'b1;
            freeze_q  <= 1'b0;
            state_q   <= StPlay;
          end
        end
        default: state_q <= StGameOver;
      endcase
    end
  end

  assign bus.lives       = lives_q;
  assign bus.dying       = dying_q;
  assign bus.death_frame = death_frame_q;
  assign bus.freeze      = freeze_q;
  assign bus.respawn     = respawn_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_lives_manager.sv
// Bench for lives_manager: two instances (3 and 5 starting lives) share stimulus
// and are compared every cycle against a ticks-remaining reference model.
module tb_lives_manager;

  localparam int DEATH = 90;
  localparam int READY = 60;
  localparam int BONUS = 10000;
  localparam int MAXL  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lives_manager_if bus3 ();
  lives_manager_if bus5 ();

  lives_manager dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  lives_manager #(
    .START_LIVES (5)
  ) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  int          n_run  = 0;
  int          n_fail = 0;
  logic [15:0] cur_score;

  // Reference model: game running flag plus ticks remaining in each pause.
  int m_start [2] = '{3, 5};
  int m_lives [2];
  bit m_in    [2];
  bit m_bonus [2];
  bit m_resp  [2];
  int m_death [2];
  int m_ready [2];

  wire [13:0] obs3 = {bus3.lives, bus3.dying, bus3.death_frame, bus3.freeze, bus3.respawn,
                      bus3.game_over};
  wire [13:0] obs5 = {bus5.lives, bus5.dying, bus5.death_frame, bus5.freeze, bus5.respawn,
                      bus5.game_over};

  function automatic logic [13:0] exp_vec(int k);
    logic [6:0] df;
    df = (m_death[k] > 0) ? 7'(DEATH - m_death[k]) : 7'd0;
    return {3'(m_lives[k]), m_death[k] > 0, df,
            (!m_in[k] || m_death[k] > 0 || m_ready[k] > 0), m_resp[k], !m_in[k]};
  endfunction

  task automatic model_step(int k, bit r, bit ng, bit hit, bit tick, logic [15:0] sc);
    int  old;
    bit  bonus;
    if (r) begin
      m_in[k] = 0; m_lives[k] = 0; m_bonus[k] = 0; m_resp[k] = 0;
      m_death[k] = 0; m_ready[k] = 0;
      return;
    end
    m_resp[k] = 0;
    if (!m_in[k]) begin
      if (ng) begin
        m_in[k] = 1; m_lives[k] = m_start[k]; m_bonus[k] = 0; m_resp[k] = 1;
      end
      return;
    end
    old   = m_lives[k];
    bonus = !m_bonus[k] && (int'(sc) >= BONUS);
    if (bonus) begin
      m_bonus[k] = 1;
      m_lives[k] = (old + 1 > MAXL) ? MAXL : old + 1;
    end
    if (m_death[k] > 0) begin
      if (tick) begin
        m_death[k]--;
        if (m_death[k] == 0) begin
          if (bonus) begin
            m_lives[k] = old;
            m_ready[k] = READY;
          end else if (old == 1) begin
            m_lives[k] = 0;
            m_in[k]    = 0;
          end else begin
            m_lives[k] = old - 1;
            m_ready[k] = READY;
          end
        end
      end
    end else if (m_ready[k] > 0) begin
      if (tick) begin
        m_ready[k]--;
        if (m_ready[k] == 0) m_resp[k] = 1;
      end
    end else if (hit) begin
      m_death[k] = DEATH;
    end
  endtask

  // Apply one cycle of stimulus to both DUTs and the model, then settle.
  task automatic step(bit r, bit ng, bit hit, bit tick, logic [15:0] sc);
    rst = r;
    bus3.new_game = ng; bus3.pacman_hit = hit; bus3.frame_tick = tick; bus3.score = sc;
    bus5.new_game = ng; bus5.pacman_hit = hit; bus5.frame_tick = tick; bus5.score = sc;
    @(posedge clk);
    model_step(0, r, ng, hit, tick, sc);
    model_step(1, r, ng, hit, tick, sc);
    #1;
  endtask

  // Hit in PLAY and run until the respawn pulse or game over; counts dying ticks.
  task automatic die_once(string tag, bit bonus_last, output int dticks);
    int guard;
    bit t;
    dticks = 0;
    step(0, 0, 1, 1'($urandom_range(0, 1)), cur_score);
    n_run++;
    if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
      n_fail++;
      $display("FAIL %s_hit got=%h,%h exp=%h,%h", tag, obs3, obs5, exp_vec(0), exp_vec(1));
    end
    guard = 0;
    while (!(m_resp[0] || !m_in[0]) && guard < 2000) begin
      t = 1'($urandom_range(0, 1));
      if (bonus_last && m_death[0] == 1 && t) cur_score = 16'(BONUS);
      if (bus3.dying && t) dticks++;
      step(0, 0, 0, t, cur_score);
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL %s_seq t=%0t got=%h,%h exp=%h,%h", tag, $time, obs3, obs5,
                 exp_vec(0), exp_vec(1));
      end
      guard++;
    end
    n_run++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d cycles exp=<2000", tag, guard);
    end
  endtask

  task automatic test_reset();
    cur_score = '0;
    repeat (3) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 16'($urandom));
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL reset got=%h,%h exp=%h,%h", obs3, obs5, exp_vec(0), exp_vec(1));
      end
    end
    n_run++;
    if (obs3 !== 14'b000_0_0000000_1_0_1) begin
      n_fail++;
      $display("FAIL reset_const got=%h exp=%h", obs3, 14'b000_0_0000000_1_0_1);
    end
    step(0, 0, 1, 1, cur_score);
    n_run++;
    if (obs3 !== 14'b000_0_0000000_1_0_1) begin
      n_fail++;
      $display("FAIL idle_hit_ignored got=%h exp=%h", obs3, 14'b000_0_0000000_1_0_1);
    end
  endtask

  task automatic test_new_game();
    step(0, 1, 0, 0, cur_score);
    n_run++;
    if ({bus3.lives, bus3.game_over, bus3.respawn, bus3.freeze} !== {3'd3, 1'b0, 1'b1, 1'b0})
    begin
      n_fail++;
      $display("FAIL new_game got=%h exp=%h", {bus3.lives, bus3.game_over, bus3.respawn,
               bus3.freeze}, {3'd3, 1'b0, 1'b1, 1'b0});
    end
    repeat (4) begin
      step(0, 1, 0, 1, cur_score);
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL play_idle got=%h,%h exp=%h,%h", obs3, obs5, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_death();
    int dt;
    die_once("death", 0, dt);
    n_run++;
    if (dt != DEATH) begin
      n_fail++;
      $display("FAIL death_ticks got=%0d exp=%0d", dt, DEATH);
    end
    n_run++;
    if ({bus3.lives, bus3.respawn, bus3.freeze} !== {3'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL death_after got=%h exp=%h", {bus3.lives, bus3.respawn, bus3.freeze},
               {3'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_game_over();
    int dt;
    die_once("go1", 0, dt);
    die_once("go2", 0, dt);
    n_run++;
    if ({bus3.lives, bus3.game_over, bus3.respawn, bus3.freeze} !== {3'd0, 1'b1, 1'b0, 1'b1})
    begin
      n_fail++;
      $display("FAIL game_over got=%h exp=%h", {bus3.lives, bus3.game_over, bus3.respawn,
               bus3.freeze}, {3'd0, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_bonus_saturate();
    int dt;
    cur_score = '0;
    step(1, 0, 0, 0, cur_score);
    step(0, 1, 0, 0, cur_score);
    foreach (m_start[i]) begin
      cur_score = (i == 0) ? 16'(BONUS) : 16'd20000;
      step(0, 0, 0, 0, cur_score);
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL bonus_step got=%h,%h exp=%h,%h", obs3, obs5, exp_vec(0), exp_vec(1));
      end
      n_run++;
      if ({bus3.lives, bus5.lives} !== {3'd4, 3'd5}) begin
        n_fail++;
        $display("FAIL bonus_lives got=%h exp=%h", {bus3.lives, bus5.lives}, {3'd4, 3'd5});
      end
    end
    die_once("bonus_die", 0, dt);
    n_run++;
    if ({bus3.lives, bus5.lives} !== {3'd3, 3'd4}) begin
      n_fail++;
      $display("FAIL bonus_no_regrant got=%h exp=%h", {bus3.lives, bus5.lives}, {3'd3, 3'd4});
    end
  endtask

  task automatic test_bonus_final_tick();
    int dt;
    cur_score = 16'd500;
    step(1, 0, 0, 0, cur_score);
    step(0, 1, 0, 0, cur_score);
    die_once("ft1", 0, dt);
    die_once("ft2", 0, dt);
    die_once("ft3", 1, dt);
    n_run++;
    if ({bus3.lives, bus3.game_over} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL final_tick_bonus got=%h exp=%h", {bus3.lives, bus3.game_over},
               {3'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid_respawn();
    int guard;
    cur_score = '0;
    step(1, 0, 0, 0, cur_score);
    step(0, 1, 0, 0, cur_score);
    step(0, 0, 1, 0, cur_score);
    guard = 0;
    while (m_ready[0] != 30 && guard < 500) begin
      step(0, 0, 0, 1, cur_score);
      guard++;
    end
    n_run++;
    if (bus3.freeze !== 1'b1 || bus3.dying !== 1'b0 || guard >= 500) begin
      n_fail++;
      $display("FAIL respawn_reach got=%b%b/%0d exp=10/<500", bus3.freeze, bus3.dying, guard);
    end
    step(1, 0, 0, 1, cur_score);
    n_run++;
    if ({bus3.lives, bus3.game_over} !== {3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_respawn got=%h exp=%h", {bus3.lives, bus3.game_over}, {3'd0, 1'b1});
    end
    repeat (200) begin
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL post_rst got=%h,%h exp=%h,%h", obs3, obs5, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_random();
    bit r, ng;
    cur_score = '0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      ng = ($urandom_range(0, 39) == 0);
      if (ng) cur_score = 16'($urandom_range(0, 9000));
      else if ($urandom_range(0, 3) == 0) cur_score = cur_score + 16'($urandom_range(0, 60));
      step(r, ng, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), cur_score);
      n_run++;
      if ({obs3, obs5} !== {exp_vec(0), exp_vec(1)}) begin
        n_fail++;
        $display("FAIL random i=%0d got=%h,%h exp=%h,%h", i, obs3, obs5, exp_vec(0),
                 exp_vec(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus3.new_game = 0; bus3.pacman_hit = 0; bus3.frame_tick = 0; bus3.score = '0;
    bus5.new_game = 0; bus5.pacman_hit = 0; bus5.frame_tick = 0; bus5.score = '0;
    #1;
    test_reset();
    test_new_game();
    test_death();
    test_game_over();
    test_bonus_saturate();
    test_bonus_final_tick();
    test_reset_mid_respawn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lives_manager.md
# lives_manager

Owns the player's life count and the death/respawn sequence; it is the producer of the `lives` value consumed by the lives HUD renderer. It sits in game control alongside the score logic, freezes gameplay while Pac-Man dies, grants one bonus life at a score threshold, and declares game over. Timing is in video frames, using a one-cycle per-frame tick.

## Interface
- START_LIVES, 3: life count loaded by `new_game`.
- MAX_LIVES, 5: saturation limit; the HUD draws at most 5.
- BONUS_SCORE, 10000: first score at or above this value awards one extra life, once per game.
- DEATH_FRAMES, 90: length of the death animation, in frames.
- RESPAWN_FRAMES, 60: "READY" pause after death, in frames.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- new_game  in  1  one-cycle start request.
- pacman_hit  in  1  one-cycle ghost-collision pulse.
- score  in  16  current score, unsigned.
- lives  out  3  lives remaining, including the one in play.
- dying  out  1  high during the death animation.
- death_frame  out  7  frame index within the death animation, 0..DEATH_FRAMES-1.
- freeze  out  1  halts Pac-Man and ghost movement.
- respawn  out  1  one-cycle pulse: reposition actors.
- game_over  out  1  high while no game is running.

## Operation
- State machine `GAME_OVER`, `PLAY`, `DYING`, `RESPAWN`. All outputs are registered.
- Reset (any cycle, mid-sequence included): state=`GAME_OVER`, lives=0, bonus_given=0, counter=0, game_over=1, freeze=1, dying=0, death_frame=0, respawn=0.
- **GAME_OVER**
  - `new_game`: lives=START_LIVES, bonus_given=0, respawn pulse, go to `PLAY`.
  - Other inputs are ignored.
- **PLAY**
  - freeze=0.
  - `pacman_hit`: counter=0, go to `DYING`.
  - `new_game` is ignored.
- **DYING**
  - freeze=1, dying=1, death_frame=counter.
  - The counter increments on each `frame_tick`.
  - On the tick with counter==DEATH_FRAMES-1:
    - If lives==1 and no bonus fires that cycle: lives=0, go to `GAME_OVER`.
    - Otherwise: decrement lives, counter=0, go to `RESPAWN`.
- **RESPAWN**
  - freeze=1.
  - On the tick with counter==RESPAWN_FRAMES-1: respawn pulse, go to `PLAY`.
- **Bonus**
  - Applies in every state except `GAME_OVER`.
  - When bonus_given==0 and score>=BONUS_SCORE: bonus_given=1 and lives=min(lives+1, MAX_LIVES).
  - If the bonus fires in the same cycle as the DYING decrement, lives is unchanged (net 0) and the block does not go to game over.
- `pacman_hit` outside `PLAY` is ignored. `frame_tick` is only counted in `DYING` and `RESPAWN`.
- Arithmetic: lives is 3-bit and never underflows or exceeds MAX_LIVES. The counter is 7-bit, which requires DEATH_FRAMES and RESPAWN_FRAMES ≤ 128.

## Timing
- Every output updates on the clk edge after the causing input. Latency is 1 cycle.
- After a qualifying `pacman_hit` at cycle N, dying and freeze are high from cycle N+1.
- dying lasts exactly DEATH_FRAMES frame_ticks. It drops on the cycle after the final tick.
- respawn is high for exactly one cycle: the first cycle of `PLAY`. freeze=0 in that same cycle.
- The bonus lives update is visible 1 cycle after score crosses the threshold.
- `pacman_hit` coincident with `frame_tick` in `PLAY`: the hit is taken and the tick is not counted.

## Structure
- Shared `game_pkg` holds:
  - the `lives_state_t` enum;
  - `LIVES_W=3`;
  - `MAX_LIVES_HW=5`, also used by the HUD;
  - `SCORE_W=16`.
- One sub-module, `frame_timer`: a clear/enable frame-tick counter with a `done` compare against a runtime limit. It is shared by `DYING` and `RESPAWN`.

## Test plan
- Reset, then `new_game` -> lives=3, game_over=0, respawn=1 for one cycle, freeze=0.
- In PLAY, `pacman_hit` with lives=3 -> dying=1 for 90 ticks, death_frame runs 0..89, then lives=2, then 60 ticks, then one respawn pulse.
- Three deaths from lives=3 with score<10000 -> after the third death animation: lives=0, game_over=1, and no respawn pulse.
- score steps to 10000 with lives=5 -> lives stays 5 and bonus_given=1. Later crossings (score 20000) give no further life.
- score crosses 10000 on the final DYING tick with lives=1 -> lives=1, state goes to `RESPAWN`, not game over.
- Assert rst during `RESPAWN` -> next cycle lives=0, game_over=1. `pacman_hit` and frame_ticks afterwards have no effect until `new_game`.
